// File: rtl/bbc_mem_pkg.sv
// Shared encodings for the BBC memory arbiter: memory-select codes, decode
// classes, arbiter states and the fixed address map.
package bbc_mem_pkg;

    localparam logic [1:0] SEL_RAM   = 2'd0;
    localparam logic [1:0] SEL_OS    = 2'd1;
    localparam logic [1:0] SEL_BASIC = 2'd2;

    typedef enum logic [2:0] {
        RAM      = 3'd0,
        OS       = 3'd1,
        BASIC    = 3'd2,
        ROMSEL   = 3'd3,
        NOP      = 3'd4,
        UNMAPPED = 3'd5
    } dec_class_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam logic [15:0] SHEILA_BASE = 16'hFE00;
    localparam logic [15:0] ROMSEL_BASE = 16'hFE30;
    localparam logic [15:0] OS_BASE     = 16'hC000;
    localparam logic [15:0] PAGED_BASE  = 16'h8000;

    // Memory-class decode results map onto the port select; anything else is RAM.
    function automatic logic [1:0] class_to_sel(input dec_class_e cls);
        logic [1:0] sel;
        case (cls)
            OS:      sel = SEL_OS;
            BASIC:   sel = SEL_BASIC;
            default: sel = SEL_RAM;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bbc_mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the shared memory port.
interface bbc_mem_arbiter_if;

    logic        P_REQ;
    logic [15:0] P_ADDR;
    logic        P_RnW;
    logic [7:0]  P_WDATA;
    logic [7:0]  P_RDATA;
    logic        P_ACK;

    logic        V_REQ;
    logic [14:0] V_ADDR;
    logic [7:0]  V_RDATA;
    logic        V_ACK;

    logic [14:0] MEM_ADDR;
    logic [1:0]  MEM_SEL;
    logic        MEM_WE;
    logic [7:0]  MEM_WDATA;
    logic [7:0]  MEM_RDATA;

    logic [3:0]  ROM_BANK;
    logic        OVERRUN;

    modport slave (
        input  P_REQ, P_ADDR, P_RnW, P_WDATA, V_REQ, V_ADDR, MEM_RDATA,
        output P_RDATA, P_ACK, V_RDATA, V_ACK, MEM_ADDR, MEM_SEL, MEM_WE,
               MEM_WDATA, ROM_BANK, OVERRUN
    );

    modport master (
        output P_REQ, P_ADDR, P_RnW, P_WDATA, V_REQ, V_ADDR, MEM_RDATA,
        input  P_RDATA, P_ACK, V_RDATA, V_ACK, MEM_ADDR, MEM_SEL, MEM_WE,
               MEM_WDATA, ROM_BANK, OVERRUN
    );

endinterface

// File: rtl/bbc_addr_decode.sv
// Combinational processor address decode: classifies a latched access and
// forms the memory-port address (ROMs only see the low 14 bits).
module bbc_addr_decode
    import bbc_mem_pkg::*;
#(
    parameter logic [3:0] BASIC_BANK = 4'h0
) (
    input  logic [15:0] addr,
    input  logic        rnw,
    input  logic [3:0]  rom_bank,
    output dec_class_e  dec_class,
    output logic [14:0] mem_addr
);

    // Priority decode: RAM, ROMSEL write, SHEILA page, OS ROM, paged BASIC.
    always_comb begin
        dec_class = UNMAPPED;
        mem_addr  = {1'b0, addr[13:0]};
        if (!addr[15]) begin
            dec_class = RAM;
            mem_addr  = addr[14:0];
        end else if (!rnw && (addr[15:4] == ROMSEL_BASE[15:4])) begin
            dec_class = ROMSEL;
        end else if (addr[15:8] == SHEILA_BASE[15:8]) begin
            dec_class = NOP;
        end else if (addr[15:14] == OS_BASE[15:14]) begin
            dec_class = OS;
        end else if ((addr[15:14] == PAGED_BASE[15:14]) && (rom_bank == BASIC_BANK)) begin
            dec_class = BASIC;
        end else begin
            dec_class = UNMAPPED;
        end
    end

endmodule

// File: rtl/bbc_mem_arbiter.sv
// Two-requester arbiter (6502 bus and CRTC video) for the shared RAM/ROM port,
// with the paged-ROM latch and a sticky overrun flag.
module bbc_mem_arbiter
    import bbc_mem_pkg::*;
#(
    parameter int unsigned VID_MAX_WAIT = 1,
    parameter logic [3:0]  BASIC_BANK   = 4'h0
) (
    input  logic              CLK100MHz,
    input  logic              RESET,
    bbc_mem_arbiter_if.slave  bus
);

    localparam int WAIT_W = (VID_MAX_WAIT < 1) ? 1 : $clog2(VID_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(VID_MAX_WAIT);

    arb_state_e        state_q, state_d;
    logic              p_pend_q, p_pend_d;
    logic [15:0]       p_addr_q, p_addr_d;
    logic              p_rnw_q, p_rnw_d;
    logic [7:0]        p_wdata_q, p_wdata_d;
    logic              v_pend_q, v_pend_d;
    logic [14:0]       v_addr_q, v_addr_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              owner_v_q, owner_v_d;
    logic              owner_rd_q, owner_rd_d;

    logic [7:0]        p_rdata_q, p_rdata_d;
    logic              p_ack_q, p_ack_d;
    logic [7:0]        v_rdata_q, v_rdata_d;
    logic              v_ack_q, v_ack_d;
    logic [14:0]       mem_addr_q, mem_addr_d;
    logic [1:0]        mem_sel_q, mem_sel_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]        rom_bank_q, rom_bank_d;
    logic              overrun_q, overrun_d;

    dec_class_e        dec_class;
    logic [14:0]       dec_mem_addr;
    logic              p_win;
    logic              v_win;
    logic              p_grant;
    logic              v_grant;

    bbc_addr_decode #(
        .BASIC_BANK (BASIC_BANK)
    ) u_decode (
        .addr      (p_addr_q),
        .rnw       (p_rnw_q),
        .rom_bank  (rom_bank_q),
        .dec_class (dec_class),
        .mem_addr  (dec_mem_addr)
    );

    // Arbitration, request queueing and next-state/output computation.
    always_comb begin
        state_d     = state_q;
        p_pend_d    = p_pend_q;
        p_addr_d    = p_addr_q;
        p_rnw_d     = p_rnw_q;
        p_wdata_d   = p_wdata_q;
        v_pend_d    = v_pend_q;
        v_addr_d    = v_addr_q;
        wait_cnt_d  = wait_cnt_q;
        owner_v_d   = owner_v_q;
        owner_rd_d  = owner_rd_q;
        p_rdata_d   = p_rdata_q;
        p_ack_d     = 1'b0;
        v_rdata_d   = v_rdata_q;
        v_ack_d     = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_sel_d   = mem_sel_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        rom_bank_d  = rom_bank_q;
        overrun_d   = overrun_q;

        // Video is forced through once it has lost VID_MAX_WAIT arbitrations in a row.
        p_win   = p_pend_q && !(v_pend_q && (wait_cnt_q >= WAIT_LIMIT));
        v_win   = v_pend_q && !p_win;
        p_grant = (state_q == IDLE) && p_win;
        v_grant = (state_q == IDLE) && v_win;

        if (bus.P_REQ) begin
            if (p_pend_q && !p_grant) begin
                overrun_d = 1'b1;
            end else begin
                p_pend_d  = 1'b1;
                p_addr_d  = bus.P_ADDR;
                p_rnw_d   = bus.P_RnW;
                p_wdata_d = bus.P_WDATA;
            end
        end else if (p_grant) begin
            p_pend_d = 1'b0;
        end else begin
            p_pend_d = p_pend_q;
        end

        if (bus.V_REQ) begin
            if (v_pend_q && !v_grant) begin
                overrun_d = 1'b1;
            end else begin
                v_pend_d = 1'b1;
                v_addr_d = bus.V_ADDR;
            end
        end else if (v_grant) begin
            v_pend_d = 1'b0;
        end else begin
            v_pend_d = v_pend_q;
        end

        case (state_q)
            IDLE: begin
                if (p_win) begin
                    if (v_pend_q && (wait_cnt_q < WAIT_LIMIT)) begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                    owner_v_d  = 1'b0;
                    owner_rd_d = p_rnw_q;
                    case (dec_class)
                        RAM, OS, BASIC: begin
                            mem_addr_d  = dec_mem_addr;
                            mem_sel_d   = class_to_sel(dec_class);
                            mem_we_d    = !p_rnw_q && (dec_class == RAM);
                            mem_wdata_d = p_wdata_q;
                            state_d     = WAIT;
                        end
                        ROMSEL: begin
                            rom_bank_d = p_wdata_q[3:0];
                            p_ack_d    = 1'b1;
                            state_d    = IDLE;
                        end
                        default: begin
                            if (p_rnw_q) begin
                                p_rdata_d = 8'hFF;
                            end else begin
                                p_rdata_d = p_rdata_q;
                            end
                            p_ack_d = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end else if (v_win) begin
                    wait_cnt_d = '0;
                    owner_v_d  = 1'b1;
                    owner_rd_d = 1'b1;
                    mem_addr_d = v_addr_q;
                    mem_sel_d  = SEL_RAM;
                    mem_we_d   = 1'b0;
                    state_d    = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                mem_we_d = 1'b0;
                state_d  = DONE;
            end
            DONE: begin
                if (owner_v_q) begin
                    v_rdata_d = bus.MEM_RDATA;
                    v_ack_d   = 1'b1;
                end else begin
                    if (owner_rd_q) begin
                        p_rdata_d = bus.MEM_RDATA;
                    end else begin
                        p_rdata_d = p_rdata_q;
                    end
                    p_ack_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK100MHz) begin
        if (RESET) begin
            state_q     <= IDLE;
            p_pend_q    <= 1'b0;
            p_addr_q    <= 16'h0000;
            p_rnw_q     <= 1'b1;
            p_wdata_q   <= 8'h00;
            v_pend_q    <= 1'b0;
            v_addr_q    <= 15'h0000;
            wait_cnt_q  <= '0;
            owner_v_q   <= 1'b0;
            owner_rd_q  <= 1'b1;
            p_rdata_q   <= 8'hFF;
            p_ack_q     <= 1'b0;
            v_rdata_q   <= 8'hFF;
            v_ack_q     <= 1'b0;
            mem_addr_q  <= 15'h0000;
            mem_sel_q   <= SEL_RAM;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            rom_bank_q  <= 4'h0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_pend_q    <= p_pend_d;
            p_addr_q    <= p_addr_d;
            p_rnw_q     <= p_rnw_d;
            p_wdata_q   <= p_wdata_d;
            v_pend_q    <= v_pend_d;
            v_addr_q    <= v_addr_d;
            wait_cnt_q  <= wait_cnt_d;
            owner_v_q   <= owner_v_d;
            owner_rd_q  <= owner_rd_d;
            p_rdata_q   <= p_rdata_d;
            p_ack_q     <= p_ack_d;
            v_rdata_q   <= v_rdata_d;
            v_ack_q     <= v_ack_d;
            mem_addr_q  <= mem_addr_d;
            mem_sel_q   <= mem_sel_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            rom_bank_q  <= rom_bank_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.P_RDATA   = p_rdata_q;
    assign bus.P_ACK     = p_ack_q;
    assign bus.V_RDATA   = v_rdata_q;
    assign bus.V_ACK     = v_ack_q;
    assign bus.MEM_ADDR  = mem_addr_q;
    assign bus.MEM_SEL   = mem_sel_q;
    // Gating with RESET keeps the RAM from latching an abandoned write on the reset edge.
    assign bus.MEM_WE    = mem_we_q & ~RESET;
    assign bus.MEM_WDATA = mem_wdata_q;
    assign bus.ROM_BANK  = rom_bank_q;
    assign bus.OVERRUN   = overrun_q;

endmodule

// File: tb/tb_bbc_mem_arbiter.sv
// Directed bench for bbc_mem_arbiter with a synchronous RAM/ROM model behind the port.
module tb_bbc_mem_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bbc_mem_arbiter_if bus ();

    bbc_mem_arbiter #(
        .VID_MAX_WAIT (1),
        .BASIC_BANK   (4'h0)
    ) dut (
        .CLK100MHz (clk),
        .RESET     (rst),
        .bus       (bus)
    );

    logic [7:0] ram [0:32767];

    function automatic logic [7:0] os_byte(input logic [13:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] basic_byte(input logic [13:0] a);
        return a[7:0] ^ 8'hC3;
    endfunction

    // Registered memory: one-cycle read latency, RAM write on MEM_WE.
    always @(posedge clk) begin
        if (bus.MEM_WE && (bus.MEM_SEL == 2'd0)) ram[bus.MEM_ADDR] <= bus.MEM_WDATA;
        case (bus.MEM_SEL)
            2'd0:    bus.MEM_RDATA <= ram[bus.MEM_ADDR];
            2'd1:    bus.MEM_RDATA <= os_byte(bus.MEM_ADDR[13:0]);
            2'd2:    bus.MEM_RDATA <= basic_byte(bus.MEM_ADDR[13:0]);
            default: bus.MEM_RDATA <= 8'h00;
        endcase
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one processor strobe; lat counts edges from the strobe edge to the visible ACK.
    task automatic p_op(input logic [15:0] a, input logic rnw, input logic [7:0] wd,
                        output int lat, output int we_cnt,
                        output logic [1:0] sel, output logic [14:0] maddr);
        bus.P_ADDR  = a;
        bus.P_RnW   = rnw;
        bus.P_WDATA = wd;
        bus.P_REQ   = 1'b1;
        tick();
        bus.P_REQ = 1'b0;
        lat = 0; we_cnt = 0; sel = 2'd3; maddr = 15'h0000;
        while (!bus.P_ACK && lat < 16) begin
            tick();
            lat++;
            if (bus.MEM_WE) we_cnt++;
            if (lat == 1) begin
                sel   = bus.MEM_SEL;
                maddr = bus.MEM_ADDR;
            end
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check_eq({pfx, "_p_rdata"},   bus.P_RDATA,   8'hFF);
        check_eq({pfx, "_v_rdata"},   bus.V_RDATA,   8'hFF);
        check_eq({pfx, "_p_ack"},     bus.P_ACK,     1'b0);
        check_eq({pfx, "_v_ack"},     bus.V_ACK,     1'b0);
        check_eq({pfx, "_mem_we"},    bus.MEM_WE,    1'b0);
        check_eq({pfx, "_mem_addr"},  bus.MEM_ADDR,  15'h0000);
        check_eq({pfx, "_mem_sel"},   bus.MEM_SEL,   2'd0);
        check_eq({pfx, "_mem_wdata"}, bus.MEM_WDATA, 8'h00);
        check_eq({pfx, "_rom_bank"},  bus.ROM_BANK,  4'h0);
        check_eq({pfx, "_overrun"},   bus.OVERRUN,   1'b0);
    endtask

    int          lat, we_cnt, n, vack, pack;
    logic [1:0]  sel;
    logic [14:0] maddr;
    bit          log_q[$];

    initial begin
        rst         = 1'b1;
        bus.P_REQ   = 1'b0;
        bus.P_ADDR  = 16'h0000;
        bus.P_RnW   = 1'b1;
        bus.P_WDATA = 8'h00;
        bus.V_REQ   = 1'b0;
        bus.V_ADDR  = 15'h0000;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_values("reset");

        // RAM write then read-back
        p_op(16'h1234, 1'b0, 8'h5A, lat, we_cnt, sel, maddr);
        check_eq("wr_lat", lat, 3);
        check_eq("wr_we_cycles", we_cnt, 1);
        check_eq("wr_sel", sel, 2'd0);
        check_eq("wr_addr", maddr, 15'h1234);
        p_op(16'h1234, 1'b1, 8'h00, lat, we_cnt, sel, maddr);
        check_eq("rd_lat", lat, 3);
        check_eq("rd_we_cycles", we_cnt, 0);
        check_eq("rd_data", bus.P_RDATA, 8'h5A);

        // Paged ROM latch, including the top of the ROMSEL window
        p_op(16'hFE30, 1'b0, 8'h07, lat, we_cnt, sel, maddr);
        check_eq("romsel_lat", lat, 1);
        check_eq("romsel_bank7", bus.ROM_BANK, 4'h7);
        p_op(16'h8000, 1'b1, 8'h00, lat, we_cnt, sel, maddr);
        check_eq("unmapped_lat", lat, 1);
        check_eq("unmapped_we", we_cnt, 0);
        check_eq("unmapped_data", bus.P_RDATA, 8'hFF);
        p_op(16'hFE3F, 1'b0, 8'h1A, lat, we_cnt, sel, maddr);
        check_eq("romsel_top_bank", bus.ROM_BANK, 4'hA);
        p_op(16'hFE30, 1'b0, 8'h00, lat, we_cnt, sel, maddr);
        check_eq("romsel_bank0", bus.ROM_BANK, 4'h0);
        p_op(16'h8000, 1'b1, 8'h00, lat, we_cnt, sel, maddr);
        check_eq("basic_lat", lat, 3);
        check_eq("basic_sel", sel, 2'd2);
        check_eq("basic_addr", maddr, 15'h0000);
        check_eq("basic_data", bus.P_RDATA, 8'hC3);

        // SHEILA NOP versus OS ROM
        p_op(16'hFE40, 1'b1, 8'h00, lat, we_cnt, sel, maddr);
        check_eq("nop_lat", lat, 1);
        check_eq("nop_data", bus.P_RDATA, 8'hFF);
        p_op(16'hFF00, 1'b1, 8'h00, lat, we_cnt, sel, maddr);
        check_eq("os_lat", lat, 3);
        check_eq("os_sel", sel, 2'd1);
        check_eq("os_addr", maddr[13:0], 14'h3F00);
        check_eq("os_data", bus.P_RDATA, 8'h03);
        p_op(16'hC000, 1'b0, 8'h77, lat, we_cnt, sel, maddr);
        check_eq("romwr_lat", lat, 3);
        check_eq("romwr_we", we_cnt, 0);
        check_eq("romwr_rdata_kept", bus.P_RDATA, 8'h03);

        // Both strobed together and re-strobed on each ACK: strict alternation
        bus.P_ADDR = 16'h1234; bus.P_RnW = 1'b1; bus.V_ADDR = 15'h1234;
        bus.P_REQ = 1'b1; bus.V_REQ = 1'b1;
        tick();
        bus.P_REQ = 1'b0; bus.V_REQ = 1'b0;
        log_q.delete();
        n = 0;
        while (log_q.size() < 4 && n < 60) begin
            tick();
            n++;
            if (bus.P_ACK) log_q.push_back(1'b0);
            if (bus.V_ACK) log_q.push_back(1'b1);
            bus.P_REQ = bus.P_ACK && (log_q.size() <= 2);
            bus.V_REQ = bus.V_ACK && (log_q.size() <= 2);
        end
        bus.P_REQ = 1'b0; bus.V_REQ = 1'b0;
        repeat (8) begin
            tick();
            if (bus.P_ACK) log_q.push_back(1'b0);
            if (bus.V_ACK) log_q.push_back(1'b1);
        end
        check_eq("alt_count", log_q.size(), 4);
        check_eq("alt_order", {log_q[0], log_q[1], log_q[2], log_q[3]}, 4'b0101);
        check_eq("alt_vdata", bus.V_RDATA, 8'h5A);

        // Processor re-queued while busy: video must still win the next slot
        bus.P_REQ = 1'b1; bus.V_REQ = 1'b1;
        tick();
        bus.P_REQ = 1'b0; bus.V_REQ = 1'b0;
        tick();
        bus.P_REQ = 1'b1;
        tick();
        bus.P_REQ = 1'b0;
        log_q.delete();
        if (bus.P_ACK) log_q.push_back(1'b0);
        if (bus.V_ACK) log_q.push_back(1'b1);
        n = 0;
        while (log_q.size() < 3 && n < 40) begin
            tick();
            n++;
            if (bus.P_ACK) log_q.push_back(1'b0);
            if (bus.V_ACK) log_q.push_back(1'b1);
        end
        check_eq("force_count", log_q.size(), 3);
        check_eq("force_order", {log_q[0], log_q[1], log_q[2]}, 3'b010);
        check_eq("force_no_overrun", bus.OVERRUN, 1'b0);

        // Second V_REQ while V_PEND is set and the processor owns the port
        bus.P_ADDR = 16'h2000; bus.P_RnW = 1'b0; bus.P_WDATA = 8'h11;
        bus.P_REQ = 1'b1;
        tick();
        bus.P_REQ = 1'b0;
        tick();
        bus.V_ADDR = 15'h2000; bus.V_REQ = 1'b1;
        tick();
        tick();
        bus.V_REQ = 1'b0;
        check_eq("overrun_set", bus.OVERRUN, 1'b1);
        vack = bus.V_ACK ? 1 : 0;
        pack = bus.P_ACK ? 1 : 0;
        repeat (12) begin
            tick();
            if (bus.V_ACK) vack++;
            if (bus.P_ACK) pack++;
        end
        check_eq("overrun_vack_count", vack, 1);
        check_eq("overrun_pack_count", pack, 1);
        check_eq("overrun_vdata", bus.V_RDATA, 8'h11);
        check_eq("overrun_sticky", bus.OVERRUN, 1'b1);

        // Reset during the WAIT cycle of a RAM write
        p_op(16'h0100, 1'b0, 8'h33, lat, we_cnt, sel, maddr);
        p_op(16'hFE30, 1'b0, 8'h05, lat, we_cnt, sel, maddr);
        check_eq("pre_rst_bank", bus.ROM_BANK, 4'h5);
        bus.P_ADDR = 16'h0100; bus.P_RnW = 1'b0; bus.P_WDATA = 8'hCC;
        bus.P_REQ = 1'b1;
        tick();
        bus.P_REQ = 1'b0;
        tick();
        check_eq("rst_we_granted", bus.MEM_WE, 1'b1);
        rst = 1'b1;
        pack = 0;
        repeat (3) begin
            tick();
            if (bus.P_ACK) pack++;
        end
        check_eq("rst_we_dropped", bus.MEM_WE, 1'b0);
        rst = 1'b0;
        repeat (5) begin
            tick();
            if (bus.P_ACK) pack++;
        end
        check_eq("rst_no_ack", pack, 0);
        check_reset_values("post_rst");
        p_op(16'h0100, 1'b1, 8'h00, lat, we_cnt, sel, maddr);
        check_eq("rst_read_lat", lat, 3);
        check_eq("rst_read_data", bus.P_RDATA, 8'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
